// File: rtl/udma_ctrl_apb_slave.sv
// udma_ctrl_apb_slave: APB slave holding the uDMA clock-gate, soft-reset and event-select registers
module udma_ctrl_apb_slave #(
    parameter int N_PERIPHS      = 8,
    parameter int WAIT_CYCLES    = 1,
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]               pwdata_i,
    input  logic                      pwrite_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic [N_PERIPHS-1:0]      cg_o,
    output logic [N_PERIPHS-1:0]      periph_rst_o,
    output logic [31:0]               evt_sel_o
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    localparam logic [3:0] WAIT = 4'(WAIT_CYCLES);
    state_t                    state;
    logic [3:0]                cnt;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic                      wr;
    logic [31:0]               wdata;
    logic [31:0]               off;
    logic [31:0]               rdata;
    logic                      err;
    logic                      active;
    logic                      done;
    logic [N_PERIPHS-1:0]      wbits;

    assign off    = 32'(addr);
    assign wbits  = wdata[N_PERIPHS-1:0];
    assign err    = !(off inside {32'h000, 32'h004, 32'h008, 32'h00C, 32'h010});
    assign active = (state != IDLE) && psel_i && penable_i;
    // the SETUP cycle with penable counts as access cycle 0, so cnt==0 there
    assign done   = active && (cnt == WAIT);

    // read mux from the latched address; write-only and unmapped offsets read 0
    always_comb begin
        rdata = off == 32'h000 ? 32'(cg_o) :
                off == 32'h00C ? 32'(periph_rst_o) :
                off == 32'h010 ? evt_sel_o : '0;
    end

    // transfer FSM, registered response and register commit on the completing edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            addr         <= '0;
            wr           <= 1'b0;
            wdata        <= '0;
            prdata_o     <= '0;
            pready_o     <= 1'b0;
            pslverr_o    <= 1'b0;
            cg_o         <= '0;
            periph_rst_o <= '0;
            evt_sel_o    <= '0;
        end else begin
            pready_o  <= done;
            prdata_o  <= done ? rdata : '0;
            pslverr_o <= done && err;
            if (done && wr && !err) begin
                if (off == 32'h000) cg_o <= wbits;
                if (off == 32'h004) cg_o <= cg_o | wbits;
                if (off == 32'h008) cg_o <= cg_o & ~wbits;
                if (off == 32'h00C) periph_rst_o <= wbits;
                if (off == 32'h010) evt_sel_o <= wdata;
            end
            case (state)
                IDLE: begin
                    if (psel_i) begin
                        addr  <= paddr_i;
                        wr    <= pwrite_i;
                        wdata <= pwdata_i;
                        cnt   <= '0;
                        state <= penable_i ? ACCESS : SETUP;
                    end
                end
                default: begin
                    if (done || !psel_i || (state == ACCESS && !penable_i)) begin
                        state <= IDLE;
                    end else if (penable_i) begin
                        state <= ACCESS;
                        cnt   <= cnt + 4'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_udma_ctrl_apb_slave.sv
// tb_udma_ctrl_apb_slave: scoreboard bench with a behavioural register model for udma_ctrl_apb_slave
module tb_udma_ctrl_apb_slave;
    localparam int W = 1;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] paddr;
    logic [31:0] pwdata, prdata, evt;
    logic        pwrite, psel, penable, pready, pslverr;
    logic [7:0]  cg, prst;

    typedef struct packed {
        logic        rd_en;
        logic [31:0] rd;
        logic        err;
        logic [7:0]  cg;
        logic [7:0]  rst;
        logic [31:0] evt;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    int          checks = 0, failures = 0;
    logic [7:0]  m_cg = '0, m_rst = '0;
    logic [31:0] m_evt = '0;
    logic        prev_rdy = 1'b0;

    always #5 clk = ~clk;

    udma_ctrl_apb_slave #(.N_PERIPHS(8), .WAIT_CYCLES(W), .APB_ADDR_WIDTH(12)) dut (
        .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite),
        .psel_i(psel), .penable_i(penable), .prdata_o(prdata), .pready_o(pready),
        .pslverr_o(pslverr), .cg_o(cg), .periph_rst_o(prst), .evt_sel_o(evt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // register model: returns the response and the register state after the transfer
    function automatic exp_t predict(input logic [11:0] a, input logic w, input logic [31:0] d);
        exp_t e;
        logic ok;
        ok = a inside {12'h000, 12'h004, 12'h008, 12'h00C, 12'h010};
        e.rd_en = !w;
        e.err = !ok;
        e.rd = '0;
        if (ok && !w) e.rd = a == 12'h000 ? {24'd0, m_cg} : a == 12'h00C ? {24'd0, m_rst} : a == 12'h010 ? m_evt : 32'd0;
        if (ok && w) begin
            if (a == 12'h000) m_cg = d[7:0];
            else if (a == 12'h004) m_cg = m_cg | d[7:0];
            else if (a == 12'h008) m_cg = m_cg & ~d[7:0];
            else if (a == 12'h00C) m_rst = d[7:0];
            else m_evt = d;
        end
        e.cg = m_cg;
        e.rst = m_rst;
        e.evt = m_evt;
        return e;
    endfunction

    // monitor: every pready pulse pops one expected response
    always @(negedge clk) begin
        if (pready) begin
            chk("pready_adjacent", {31'd0, prev_rdy}, 32'd0);
            if (q.size() == 0) chk("unexpected_pready", 32'd1, 32'd0);
            else begin
                me = q.pop_front();
                if (me.rd_en) chk("prdata", prdata, me.rd);
                chk("pslverr", {31'd0, pslverr}, {31'd0, me.err});
                chk("cg_o", {24'd0, cg}, {24'd0, me.cg});
                chk("periph_rst_o", {24'd0, prst}, {24'd0, me.rst});
                chk("evt_sel_o", evt, me.evt);
            end
        end
        prev_rdy = pready;
    end

    task automatic apb(input logic [11:0] a, input logic w, input logic [31:0] d);
        int lat = 0;
        logic seen = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        q.push_back(predict(a, w, d));
        paddr = 12'($urandom); pwdata = $urandom; pwrite = 1'($urandom);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (pready) begin seen = 1'b1; lat = k; end
        end
        chk("pready_timeout", {31'd0, seen}, 32'd1);
        chk("latency", lat, W + 1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic start_wr(input logic [11:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = 1'b1; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
    endtask

    task automatic chk_outs(input string name);
        chk({name, "_cg"}, {24'd0, cg}, {24'd0, m_cg});
        chk({name, "_rst"}, {24'd0, prst}, {24'd0, m_rst});
        chk({name, "_evt"}, evt, m_evt);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [11:0] ba[4];
        logic [11:0] ra[11];
        logic seen;
        ba = '{12'h000, 12'h00C, 12'h010, 12'h004};
        ra = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h020, 12'h002, 12'h07F, 12'h400, 12'h80C};
        rst = 1'b1; psel = 1'b0; penable = 1'b0; paddr = '0; pwdata = '0; pwrite = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_outs("reset");
        chk("reset_prdata", prdata, 32'd0);
        chk("reset_pready", {31'd0, pready}, 32'd0);
        chk("reset_pslverr", {31'd0, pslverr}, 32'd0);
        apb(12'h000, 1'b0, 32'd0);
        apb(12'h000, 1'b1, 32'hFFFF_FF05);
        apb(12'h000, 1'b0, 32'd0);
        chk("cg_after_write", {24'd0, cg}, 32'h05);
        apb(12'h004, 1'b1, 32'h12);
        chk("cg_after_set", {24'd0, cg}, 32'h17);
        apb(12'h008, 1'b1, 32'h04);
        chk("cg_after_clr", {24'd0, cg}, 32'h13);
        apb(12'h004, 1'b0, 32'd0);
        apb(12'h008, 1'b0, 32'd0);
        apb(12'h010, 1'b1, 32'hA1B2_C3D4);
        apb(12'h00C, 1'b1, 32'h80);
        apb(12'h020, 1'b1, 32'hFFFF_FFFF);
        apb(12'h002, 1'b0, 32'd0);
        apb(12'h002, 1'b1, 32'hFFFF_FFFF);
        chk_outs("after_unmapped");
        // abort: psel drops one cycle into the access phase
        start_wr(12'h000, 32'hFF);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (4) @(negedge clk);
        chk_outs("abort");
        apb(12'h000, 1'b0, 32'd0);
        // reset while in the access phase, on the edge that would have completed it
        start_wr(12'h010, 32'h1234_5678);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        m_cg = '0; m_rst = '0; m_evt = '0;
        @(negedge clk);
        chk_outs("mid_reset");
        chk("mid_reset_pready", {31'd0, pready}, 32'd0);
        apb(12'h000, 1'b1, 32'hA5);
        apb(12'h00C, 1'b1, 32'h3C);
        apb(12'h010, 1'b1, 32'hDEAD_BEEF);
        // back-to-back reads with psel/penable held high
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = ba[0]; pwrite = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        q.push_back(predict(ba[0], 1'b0, 32'd0));
        for (int i = 0; i < 4; i++) begin
            int gap = 0;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (pready) begin seen = 1'b1; gap = k; end
            end
            chk("burst_timeout", {31'd0, seen}, 32'd1);
            chk("burst_gap", gap, W + 1);
            if (i < 3) begin
                paddr = ba[i+1];
                q.push_back(predict(ba[i+1], 1'b0, 32'd0));
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        // randomized transfers against the model
        repeat (40) apb(ra[$urandom_range(0, 10)], 1'($urandom), $urandom);
        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        chk_outs("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
